// File: rtl/usb_txn_engine.sv
// Host-side USB transaction engine: token, DATA0/DATA1 and handshake sequencing
// with per-endpoint data toggles, a handshake timeout and bounded retries.
module usb_txn_engine #(
  parameter int DATA_W      = 64,
  parameter int TIMEOUT_CYC = 20,
  parameter int MAX_RETRY   = 8,
  parameter int NUM_EP      = 16
) (
  input  logic              clk,
  input  logic              rst_L,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_dir,
  input  logic [6:0]        req_addr,
  input  logic [3:0]        req_endp,
  input  logic [DATA_W-1:0] req_data,
  input  logic              tog_clr,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [3:0]        tx_pid,
  output logic [6:0]        tx_addr,
  output logic [3:0]        tx_endp,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_has_data,
  input  logic              rx_valid,
  input  logic [3:0]        rx_pid,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_corrupt,
  output logic              done,
  output logic              status,
  output logic [DATA_W-1:0] rsp_data
);
  localparam int EPW = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
  localparam int TW  = $clog2(TIMEOUT_CYC);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;

  typedef enum logic [3:0] {
    S_IDLE, S_TOKEN, S_DATA, S_WAIT_HS, S_WAIT_DATA,
    S_HS_GOOD, S_HS_DUP, S_FAIL, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              dir_q, dir_d;
  logic [6:0]        addr_q, addr_d;
  logic [3:0]        endp_q, endp_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] rsp_q, rsp_d;
  logic [7:0]        retry_q, retry_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [NUM_EP-1:0] tog_q, tog_d;
  logic              dtog_q, dtog_d;
  logic              status_q, status_d;
  logic [EPW-1:0]    ep;
  logic              tmo, flip, rx_is_data;

  assign ep         = endp_q[EPW-1:0];
  assign tmo        = (tmr_q == TW'(TIMEOUT_CYC - 1));
  assign rx_is_data = (rx_pid == PID_DATA0) || (rx_pid == PID_DATA1);
  assign req_ready  = (state_q == S_IDLE);
  assign done       = (state_q == S_DONE);
  assign status     = status_q;
  assign rsp_data   = rsp_q;

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    addr_d      = addr_q;
    endp_d      = endp_q;
    data_d      = data_q;
    rsp_d       = rsp_q;
    retry_d     = retry_q;
    tmr_d       = tmr_q;
    dtog_d      = dtog_q;
    status_d    = status_q;
    flip        = 1'b0;
    tx_valid    = 1'b0;
    tx_pid      = '0;
    tx_addr     = '0;
    tx_endp     = '0;
    tx_data     = '0;
    tx_has_data = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          dir_d   = req_dir;
          addr_d  = req_addr;
          endp_d  = req_endp;
          data_d  = req_data;
          retry_d = '0;
          state_d = S_TOKEN;
        end
      end
      S_TOKEN: begin
        tx_valid = 1'b1;
        tx_pid   = dir_q ? PID_IN : PID_OUT;
        tx_addr  = addr_q;
        tx_endp  = endp_q;
        if (tx_ready) begin
          tmr_d   = '0;
          // freeze the DATA PID so a later clear cannot alter it mid-stall
          dtog_d  = tog_clr ? 1'b0 : tog_q[ep];
          state_d = dir_q ? S_WAIT_DATA : S_DATA;
        end
      end
      S_DATA: begin
        tx_valid    = 1'b1;
        tx_pid      = dtog_q ? PID_DATA1 : PID_DATA0;
        tx_data     = data_q;
        tx_has_data = 1'b1;
        if (tx_ready) begin
          tmr_d   = '0;
          state_d = S_WAIT_HS;
        end
      end
      S_WAIT_HS: begin
        if (rx_valid) begin
          if (!rx_corrupt && rx_pid == PID_ACK) begin
            flip     = 1'b1;
            status_d = 1'b0;
            state_d  = S_DONE;
          end else begin
            state_d = S_FAIL;
          end
        end else if (tmo) begin
          state_d = S_FAIL;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_WAIT_DATA: begin
        if (rx_valid) begin
          if (rx_corrupt || !rx_is_data) begin
            state_d = S_FAIL;
          end else if (rx_pid[3] == tog_q[ep]) begin
            data_d  = rx_data;
            flip    = 1'b1;
            state_d = S_HS_GOOD;
          end else begin
            state_d = S_HS_DUP;
          end
        end else if (tmo) begin
          state_d = S_FAIL;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_HS_GOOD: begin
        tx_valid = 1'b1;
        tx_pid   = PID_ACK;
        if (tx_ready) begin
          rsp_d    = data_q;
          status_d = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_HS_DUP: begin
        tx_valid = 1'b1;
        tx_pid   = PID_ACK;
        if (tx_ready) state_d = S_FAIL;
      end
      S_FAIL: begin
        retry_d = retry_q + 8'd1;
        if (retry_d == 8'(MAX_RETRY)) begin
          status_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          state_d = S_TOKEN;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    tog_d = tog_q;
    if (flip) tog_d[ep] = ~tog_q[ep];
    if (tog_clr) tog_d = '0;
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q  <= S_IDLE;
      dir_q    <= 1'b0;
      addr_q   <= '0;
      endp_q   <= '0;
      data_q   <= '0;
      rsp_q    <= '0;
      retry_q  <= '0;
      tmr_q    <= '0;
      tog_q    <= '0;
      dtog_q   <= 1'b0;
      status_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      addr_q   <= addr_d;
      endp_q   <= endp_d;
      data_q   <= data_d;
      rsp_q    <= rsp_d;
      retry_q  <= retry_d;
      tmr_q    <= tmr_d;
      tog_q    <= tog_d;
      dtog_q   <= dtog_d;
      status_q <= status_d;
    end
  end
endmodule

// File: doc/usb_txn_engine.md
Name: usb_txn_engine

Overview:
Parametrised host-side USB transaction engine. Sits between the read/write FSM (request/response side) and the packet encoder/decoder (tx/rx side). Runs complete OUT and IN transactions: token, DATA0/DATA1, handshake. Adds per-endpoint data-toggle tracking, a configurable timeout and retry limit, and valid/ready handshakes on both sides.

Parameters:
DATA_W, 64, payload width in bits
TIMEOUT_CYC, 20, cycles waited for a handshake or data before one retry is charged (>=2)
MAX_RETRY, 8, failed attempts before the transaction is cancelled (1..255)
NUM_EP, 16, number of toggle bits (power of 2, <=16); indexed by req_endp[log2(NUM_EP)-1:0]

Ports:
clk  in  1  clock
rst_L  in  1  asynchronous active-low reset
req_valid  in  1  transaction request
req_ready  out  1  engine idle; request accepted when valid&ready
req_dir  in  1  0=OUT, 1=IN
req_addr  in  7  device address
req_endp  in  4  endpoint
req_data  in  DATA_W  OUT payload
tog_clr  in  1  clear all toggle bits to DATA0
tx_valid  out  1  packet to encoder
tx_ready  in  1  encoder accepts packet
tx_pid  out  4  PID to send
tx_addr  out  7  token address (0 for non-token)
tx_endp  out  4  token endpoint (0 for non-token)
tx_data  out  DATA_W  payload (0 for non-data)
tx_has_data  out  1  1 for DATA0/DATA1 packets
rx_valid  in  1  decoded packet present (1-cycle pulse)
rx_pid  in  4  received PID
rx_data  in  DATA_W  received payload
rx_corrupt  in  1  CRC/PID-check failure
done  out  1  1-cycle completion pulse
status  out  1  with done: 0=success, 1=cancelled
rsp_data  out  DATA_W  IN payload; valid with done&~status, held until next done

Behaviour:
- PIDs: OUT 0001, IN 1001, DATA0 0011, DATA1 1011, ACK 0010, NAK 1010.
- Reset values: state IDLE, toggles 0, retry and timer 0, rsp_data 0, done/status/tx_valid 0, tx_* 0.
- Reset mid-transaction aborts immediately. No done is issued.
- req_ready=1 only in IDLE. The accept cycle latches dir, addr, endp, data and clears retry.
- tx_valid and tx_* stay stable from assertion until the tx_ready cycle.
- States:
  - IDLE: on accept -> TOKEN.
  - TOKEN: drive IN/OUT token. On tx_ready -> DATA (OUT) or WAIT_DATA (IN). Timer cleared.
  - DATA: drive DATA0/DATA1 per toggle[ep] with the latched payload, tx_has_data=1. On tx_ready -> WAIT_HS, timer cleared.
  - WAIT_HS:
    - rx_valid & ~rx_corrupt & ACK -> flip toggle[ep], DONE ok.
    - rx_valid with NAK, corrupt or any other PID -> FAIL.
    - No rx by timer==TIMEOUT_CYC-1 -> FAIL.
  - WAIT_DATA:
    - rx_valid & corrupt -> FAIL, no handshake sent.
    - NAK -> FAIL.
    - DATAx matching toggle -> capture rx_data, flip toggle, HS_GOOD.
    - DATAx mismatching toggle (duplicate) -> HS_DUP.
    - Other PID -> FAIL.
    - Timeout -> FAIL.
  - HS_GOOD: drive ACK. On tx_ready -> DONE ok.
  - HS_DUP: drive ACK, discard data. On tx_ready -> FAIL.
  - FAIL: retry+1. If the new count == MAX_RETRY -> DONE cancelled, else -> TOKEN (full re-transaction, same toggle).
  - DONE: done=1 for one cycle, status set -> IDLE (req_ready one cycle later).
- rx_valid in the same cycle as the timeout boundary: rx wins.
- rx_valid outside WAIT_HS/WAIT_DATA is ignored.
- Timer saturates and holds while in TOKEN/DATA/HS states; it only counts in the wait states.
- tog_clr:
  - Synchronous; clears all toggles.
  - Clear beats a simultaneous flip.
  - In DATA it does not alter a packet already presented.
- Cancelled transactions never flip a toggle. rsp_data updates only on IN success.

Test Plan:
- OUT addr 7 endp 3 data AABBCCDD, tx_ready=1, ACK 2 cycles after DATA -> sequence OUT, DATA0; done status 0; next OUT to endp 3 sends DATA1.
- IN endp 2, device returns DATA0 0x1234 -> ACK sent; done status 0; rsp_data=0x1234; toggle[2]=1.
- OUT with no response, MAX_RETRY=8 -> 8 OUT+DATA0 sequences spaced TIMEOUT_CYC; done status 1; toggle unchanged.
- IN with NAK twice then DATA0 -> three IN tokens; success; retry charged 2.
- IN receives DATA1 while expecting DATA0 -> ACK sent, data discarded, IN reissued; then DATA0 -> rsp_data updated.
- tx_ready held low 10 cycles in TOKEN, then rst_L low mid-WAIT_HS -> tx outputs stable while stalled; after reset IDLE, req_ready=1, toggles 0, no done.
